// File: rtl/ram4002_responder.sv
// -----------------------------------------------------------------------------
// ram4002_responder
//
// MCS-4 4002-style RAM / output-port responder on the 4-bit multiplexed CPU
// data bus. It follows the eight-phase instruction cycle (A1..X3) using the
// step strobe and SYNC. It latches SRC chip/register/character addresses and
// executes the RAM and output-port I/O instructions addressed to this chip.
//
// Parameters
//   CHIP_ID   chip number, matched against SRC high nibble bits [3:2]
//
// Ports
//   sysclk    in   system clock, the only clock
//   poc       in   power-on clear, synchronous, active-high
//   step      in   one-sysclk strobe at the end of each bus phase
//   sync      in   SYNC, high on the step that ends X3 (forces A1)
//   cm_ram    in   CM-RAM line for this bank (sampled at M2 and X2 ends)
//   data_in   in   [3:0] bus value as seen by this chip
//   data_out  out  [3:0] value driven onto the bus (4'h0 when not driving)
//   data_dir  out  1 = chip drives the bus during X2 of a selected read
//   oport     out  [3:0] output port latch
// -----------------------------------------------------------------------------
module ram4002_responder #(
    parameter logic [1:0] CHIP_ID = 2'b00
) (
    input  logic       sysclk,
    input  logic       poc,
    input  logic       step,
    input  logic       sync,
    input  logic       cm_ram,
    input  logic [3:0] data_in,
    output logic [3:0] data_out,
    output logic       data_dir,
    output logic [3:0] oport
);

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    // Phase sequencer
    phase_e phase_q, phase_d;

    // Phase-derived strobes, each qualified by step
    logic end_m1, end_m2, end_x2, end_x3, enter_x2;

    // Instruction and address registers
    logic [3:0] opr_q,      opr_d;
    logic [3:0] opa_q,      opa_d;
    logic       io_cyc_q,   io_cyc_d;
    logic       sel_q,      sel_d;
    logic [1:0] reg_sel_q,  reg_sel_d;
    logic [3:0] chr_q,      chr_d;
    logic       src_pend_q, src_pend_d;

    // Storage: main characters indexed {reg, chr}, status indexed {reg, n}
    logic [3:0] main_q   [64];
    logic [3:0] main_d   [64];
    logic [3:0] status_q [16];
    logic [3:0] status_d [16];

    // Outputs
    logic [3:0] oport_q,    oport_d;
    logic       data_dir_q, data_dir_d;
    logic [3:0] data_out_q, data_out_d;

    // Instruction decode
    logic       io_act;
    logic       op_wrm, op_wmp, op_wrs, op_rd;
    logic [5:0] main_idx;
    logic [3:0] stat_idx;
    logic [3:0] rd_val;

    // ------------------------------------------------------------------
    // Phase FSM: state register
    // ------------------------------------------------------------------
    // After clear the sequencer sits in X3 so the first step enters A1.
    always_ff @(posedge sysclk) begin
        if (poc) begin
            phase_q <= PH_X3;
        end else begin
            phase_q <= phase_d;
        end
    end

    // ------------------------------------------------------------------
    // Phase FSM: next state
    // ------------------------------------------------------------------
    // SYNC in any phase forces A1; otherwise the 3-bit count wraps X3->A1.
    always_comb begin
        phase_d = phase_q;
        if (step) begin
            if (sync) begin
                phase_d = PH_A1;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Phase FSM: outputs (phase-boundary strobes)
    // ------------------------------------------------------------------
    always_comb begin
        end_m1   = step && (phase_q == PH_M1);
        end_m2   = step && (phase_q == PH_M2);
        end_x2   = step && (phase_q == PH_X2);
        end_x3   = step && (phase_q == PH_X3);
        enter_x2 = step && (phase_d == PH_X2);
    end

    // ------------------------------------------------------------------
    // Instruction decode and read mux
    // ------------------------------------------------------------------
    always_comb begin
        io_act   = io_cyc_q && sel_q;
        op_wrm   = (opa_q == 4'h0);
        op_wmp   = (opa_q == 4'h1);
        op_wrs   = (opa_q[3:2] == 2'b01);
        // 8, 9, B, C-F read; A is a ROM-port read and is not ours.
        op_rd    = opa_q[3] && (opa_q != 4'hA);
        main_idx = {reg_sel_q, chr_q};
        stat_idx = {reg_sel_q, opa_q[1:0]};
        // Status reads (C-F) have opa[2] set; SBM/RDM/ADM (8, 9, B) do not.
        if (opa_q[2]) begin
            rd_val = status_q[stat_idx];
        end else begin
            rd_val = main_q[main_idx];
        end
    end

    // ------------------------------------------------------------------
    // Next-state datapath
    // ------------------------------------------------------------------
    always_comb begin
        opr_d      = opr_q;
        opa_d      = opa_q;
        io_cyc_d   = io_cyc_q;
        sel_d      = sel_q;
        reg_sel_d  = reg_sel_q;
        chr_d      = chr_q;
        src_pend_d = src_pend_q;
        oport_d    = oport_q;
        data_dir_d = data_dir_q;
        data_out_d = data_out_q;
        main_d     = main_q;
        status_d   = status_q;

        if (end_m1) begin
            opr_d = data_in;
        end

        if (end_m2) begin
            opa_d    = data_in;
            io_cyc_d = (opr_q == 4'hE) && cm_ram;
        end

        if (end_x2) begin
            // CM-RAM at X2 is an SRC only outside an I/O cycle.
            if (cm_ram && !io_cyc_q) begin
                sel_d      = (data_in[3:2] == CHIP_ID);
                reg_sel_d  = data_in[1:0];
                src_pend_d = 1'b1;
            end
            if (io_act) begin
                if (op_wrm) begin
                    main_d[main_idx] = data_in;
                end
                if (op_wmp) begin
                    oport_d = data_in;
                end
                if (op_wrs) begin
                    status_d[stat_idx] = data_in;
                end
            end
        end

        if (end_x3) begin
            io_cyc_d = 1'b0;
            if (src_pend_q) begin
                chr_d      = data_in;
                src_pend_d = 1'b0;
            end
        end

        // The drive window is re-evaluated on every step, so it opens on
        // the step entering X2 and closes on the step leaving it.
        if (step) begin
            data_dir_d = enter_x2 && io_act && op_rd;
            data_out_d = data_dir_d ? rd_val : 4'h0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (poc) begin
            opr_q      <= 4'h0;
            opa_q      <= 4'h0;
            io_cyc_q   <= 1'b0;
            sel_q      <= 1'b0;
            reg_sel_q  <= 2'b00;
            chr_q      <= 4'h0;
            src_pend_q <= 1'b0;
            oport_q    <= 4'h0;
            data_dir_q <= 1'b0;
            data_out_q <= 4'h0;
            main_q     <= '{default: 4'h0};
            status_q   <= '{default: 4'h0};
        end else begin
            opr_q      <= opr_d;
            opa_q      <= opa_d;
            io_cyc_q   <= io_cyc_d;
            sel_q      <= sel_d;
            reg_sel_q  <= reg_sel_d;
            chr_q      <= chr_d;
            src_pend_q <= src_pend_d;
            oport_q    <= oport_d;
            data_dir_q <= data_dir_d;
            data_out_q <= data_out_d;
            main_q     <= main_d;
            status_q   <= status_d;
        end
    end

    assign data_out = data_out_q;
    assign data_dir = data_dir_q;
    assign oport    = oport_q;

endmodule

// File: tb/tb_ram4002_responder.sv
// -----------------------------------------------------------------------------
// tb_ram4002_responder
//
// Directed bench for ram4002_responder (CHIP_ID = 2). Each bus phase is one
// step; after every step the bench checks oport and the drive window. Reads
// push their expected value onto a scoreboard queue when the instruction is
// issued; the value is popped and compared when the chip drives in X2.
// -----------------------------------------------------------------------------
module tb_ram4002_responder;

    logic       sysclk = 1'b0;
    logic       poc;
    logic       step;
    logic       sync;
    logic       cm_ram;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       data_dir;
    logic [3:0] oport;

    always #10 sysclk = ~sysclk;

    ram4002_responder #(
        .CHIP_ID(2'b10)
    ) dut (
        .sysclk  (sysclk),
        .poc     (poc),
        .step    (step),
        .sync    (sync),
        .cm_ram  (cm_ram),
        .data_in (data_in),
        .data_out(data_out),
        .data_dir(data_dir),
        .oport   (oport)
    );

    int         total = 0;
    int         bad   = 0;
    int         tb_phase;
    int         gap;
    logic       exp_drive;
    logic [3:0] exp_oport;
    logic [3:0] exp_oport_new;
    logic [3:0] sb[$];

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; leaves the bench at a falling edge so that
    // consecutive calls with gap=0 give back-to-back steps.
    task automatic do_step(input logic s, input logic cm, input logic [3:0] d);
        int         prev;
        logic [3:0] e;
        sync    = s;
        cm_ram  = cm;
        data_in = d;
        step    = 1'b1;
        @(negedge sysclk);
        step   = 1'b0;
        sync   = 1'b0;
        cm_ram = 1'b0;
        prev     = tb_phase;
        tb_phase = s ? 0 : (tb_phase + 1) % 8;
        if (prev == 6) exp_oport = exp_oport_new;
        chk("oport", oport, exp_oport);
        if (tb_phase == 6) begin
            chk("dir_x2", {3'b000, data_dir}, {3'b000, exp_drive});
            if (exp_drive && sb.size() > 0) begin
                e = sb.pop_front();
                chk("rd_data", data_out, e);
            end else begin
                chk("dout_x2_idle", data_out, 4'h0);
            end
        end else begin
            chk("dir_off", {3'b000, data_dir}, 4'h0);
            chk("dout_off", data_out, 4'h0);
        end
        repeat (gap) @(negedge sysclk);
    endtask

    task automatic cycle(input logic [3:0] opr, input logic [3:0] opa,
                         input logic cm_m2, input logic cm_x2,
                         input logic [3:0] dx2, input logic [3:0] dx3,
                         input logic rd, input logic [3:0] rv);
        exp_drive = rd;
        if (rd) sb.push_back(rv);
        do_step(1'b0, 1'b0, 4'h0);     // A1
        do_step(1'b0, 1'b0, 4'h0);     // A2
        do_step(1'b0, 1'b0, 4'h0);     // A3
        do_step(1'b0, 1'b0, opr);      // M1
        do_step(1'b0, cm_m2, opa);     // M2
        do_step(1'b0, 1'b0, 4'h0);     // X1 -> X2 window check
        do_step(1'b0, cm_x2, dx2);     // X2
        do_step(1'b1, 1'b0, dx3);      // X3 with SYNC
        exp_drive = 1'b0;
    endtask

    task automatic src(input logic [3:0] hi, input logic [3:0] lo);
        cycle(4'h2, 4'h1, 1'b0, 1'b1, hi, lo, 1'b0, 4'h0);
    endtask

    task automatic io(input logic [3:0] opa, input logic [3:0] d,
                      input logic rd, input logic [3:0] rv);
        cycle(4'hE, opa, 1'b1, 1'b0, d, 4'h0, rd, rv);
    endtask

    task automatic do_poc(input logic with_step, input logic [3:0] d);
        poc     = 1'b1;
        step    = with_step;
        data_in = d;
        @(negedge sysclk);
        poc           = 1'b0;
        step          = 1'b0;
        tb_phase      = 7;
        exp_drive     = 1'b0;
        exp_oport     = 4'h0;
        exp_oport_new = 4'h0;
        chk("poc_dir", {3'b000, data_dir}, 4'h0);
        chk("poc_dout", data_out, 4'h0);
        chk("poc_oport", oport, 4'h0);
    endtask

    initial begin
        poc           = 1'b1;
        step          = 1'b0;
        sync          = 1'b0;
        cm_ram        = 1'b0;
        data_in       = 4'h0;
        gap           = 0;
        tb_phase      = 7;
        exp_drive     = 1'b0;
        exp_oport     = 4'h0;
        exp_oport_new = 4'h0;
        @(negedge sysclk);

        // Reset, enter A1, one idle instruction cycle
        do_poc(1'b0, 4'h0);
        do_step(1'b1, 1'b0, 4'h0);
        cycle(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);

        // SRC chip 2 reg 1 chr 5; RD0 of cleared status reads 0
        src(4'b1001, 4'h5);
        io(4'hC, 4'h0, 1'b1, 4'h0);

        // WRM then RDM / ADM / SBM
        io(4'h0, 4'hA, 1'b0, 4'h0);
        io(4'h9, 4'h0, 1'b1, 4'hA);
        io(4'hB, 4'h0, 1'b1, 4'hA);
        io(4'h8, 4'h0, 1'b1, 4'hA);

        // Status write/read with spaced steps
        gap = 2;
        io(4'h6, 4'h3, 1'b0, 4'h0);
        io(4'hE, 4'h0, 1'b1, 4'h3);
        io(4'hC, 4'h0, 1'b1, 4'h0);
        gap = 0;

        // WMP: oport changes exactly on the step ending X2
        exp_oport_new = 4'hC;
        io(4'h1, 4'hC, 1'b0, 4'h0);

        // ROM-port operations and non-I/O cycles: no drive, no write
        io(4'h2, 4'h5, 1'b0, 4'h0);
        io(4'h3, 4'h5, 1'b0, 4'h0);
        io(4'hA, 4'h5, 1'b0, 4'h0);
        cycle(4'hD, 4'h9, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);

        // Deselect: writes and reads ignored
        src(4'b0001, 4'h5);
        io(4'h0, 4'h7, 1'b0, 4'h0);
        io(4'h9, 4'h0, 1'b0, 4'h0);
        io(4'h1, 4'h3, 1'b0, 4'h0);
        src(4'b1001, 4'h5);
        io(4'h9, 4'h0, 1'b1, 4'hA);

        // Different character and register
        src(4'b1001, 4'h6);
        io(4'h0, 4'h5, 1'b0, 4'h0);
        io(4'h9, 4'h0, 1'b1, 4'h5);
        src(4'b1010, 4'h5);
        io(4'h9, 4'h0, 1'b1, 4'h0);
        src(4'b1001, 4'h5);
        io(4'h9, 4'h0, 1'b1, 4'hA);

        // CM-RAM at X2 of an I/O cycle is not an SRC
        cycle(4'hE, 4'h9, 1'b1, 1'b1, 4'b0001, 4'h3, 1'b1, 4'hA);
        io(4'h9, 4'h0, 1'b1, 4'hA);

        // Resync: SYNC at M1 returns to A1
        do_step(1'b0, 1'b0, 4'h0);
        do_step(1'b0, 1'b0, 4'h0);
        do_step(1'b0, 1'b0, 4'h0);
        do_step(1'b1, 1'b0, 4'hE);
        chk("resync_phase", tb_phase[3:0], 4'h0);
        io(4'h9, 4'h0, 1'b1, 4'hA);

        // poc during X2 of an RDM
        exp_drive = 1'b1;
        sb.push_back(4'hA);
        do_step(1'b0, 1'b0, 4'h0);
        do_step(1'b0, 1'b0, 4'h0);
        do_step(1'b0, 1'b0, 4'h0);
        do_step(1'b0, 1'b0, 4'hE);
        do_step(1'b0, 1'b1, 4'h9);
        do_step(1'b0, 1'b0, 4'h0);
        do_poc(1'b1, 4'h0);
        do_step(1'b1, 1'b0, 4'h0);
        src(4'b1001, 4'h5);
        io(4'h9, 4'h0, 1'b1, 4'h0);
        io(4'hE, 4'h0, 1'b1, 4'h0);

        // poc on the step ending X2 of a WMP: port write does not complete
        do_step(1'b0, 1'b0, 4'h0);
        do_step(1'b0, 1'b0, 4'h0);
        do_step(1'b0, 1'b0, 4'h0);
        do_step(1'b0, 1'b0, 4'hE);
        do_step(1'b0, 1'b1, 4'h1);
        do_step(1'b0, 1'b0, 4'h0);
        do_poc(1'b1, 4'hF);

        chk("sb_empty", {3'b000, sb.size() == 0}, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
